// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of mem_port_arbiter: two request/grant ports (A = DMA, B = CPU)
// with per-requester read-data return.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a simple-dual-port RAM (1 write, 1 registered 2-cycle read port) between a
// high-priority DMA (A) and a CPU (B) with starvation guard and optional post-reset zero-fill.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_DEPTH      = 2048,
  parameter int ADDR_WIDTH     = 11,
  parameter int MAX_WAIT       = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_addrW,
  output logic [DATA_WIDTH-1:0] ram_Din,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addrR,
  output logic                  ram_enR,
  output logic                  ram_regceb,
  output logic                  ram_rstb,
  input  logic [DATA_WIDTH-1:0] ram_Dout,
  output logic                  init_done
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [WAIT_W-1:0]     b_wait;
  logic [1:0]            tag_vld;
  logic [1:0]            tag_own_b;

  logic run, b_prio;
  logic a_w, a_r, b_w, b_r;
  logic wr_a, wr_b, rd_a, rd_b;

  assign run    = (state == ST_RUN);
  assign b_prio = (b_wait >= WAIT_W'(MAX_WAIT));

  assign a_w = bus.a_req &  bus.a_we;
  assign a_r = bus.a_req & ~bus.a_we;
  assign b_w = bus.b_req &  bus.b_we;
  assign b_r = bus.b_req & ~bus.b_we;

  // Each slot is arbitrated on its own: B takes a contested slot only once starved.
  assign wr_b = run & b_w & (~a_w | b_prio);
  assign wr_a = run & a_w & ~wr_b;
  assign rd_b = run & b_r & (~a_r | b_prio);
  assign rd_a = run & a_r & ~rd_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      clr_addr  <= '0;
      b_wait    <= '0;
      tag_vld   <= '0;
      tag_own_b <= '0;
    end else begin
      state     <= state_nxt;
      tag_vld   <= {tag_vld[0], rd_a | rd_b};
      tag_own_b <= {tag_own_b[0], rd_b};
      if (state == ST_INIT)
        clr_addr <= clr_addr + 1'b1;
      if (!bus.b_req || bus.b_gnt)
        b_wait <= '0;
      else if (run && (b_wait < WAIT_W'(MAX_WAIT)))
        b_wait <= b_wait + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    bus.a_gnt  = 1'b0;
    bus.b_gnt  = 1'b0;
    ram_we     = 1'b0;
    ram_addrW  = '0;
    ram_Din    = '0;
    ram_enR    = 1'b0;
    ram_addrR  = '0;
    case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addrW = clr_addr;
        if (clr_addr == LAST_ADDR)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        bus.a_gnt = wr_a | rd_a;
        bus.b_gnt = wr_b | rd_b;
        ram_we    = wr_a | wr_b;
        ram_addrW = wr_b ? bus.b_addr  : bus.a_addr;
        ram_Din   = wr_b ? bus.b_wdata : bus.a_wdata;
        ram_enR   = rd_a | rd_b;
        ram_addrR = rd_b ? bus.b_addr  : bus.a_addr;
      end
    endcase
  end

  assign bus.a_rvalid = tag_vld[1] & ~tag_own_b[1];
  assign bus.b_rvalid = tag_vld[1] &  tag_own_b[1];
  assign bus.a_rdata  = ram_Dout;
  assign bus.b_rdata  = ram_Dout;

  assign ram_regceb = 1'b1;
  assign ram_rstb   = reset;
  assign init_done  = run;

endmodule
